dmem_ctrl: RTL and testbench

Access controller in front of the single-port data memory of the pipelined MIPS core. It shares the one read/write port between the pipeline MEM stage and a burst loader, which fills a contiguous word region from an external stream (program data preload, scrub). It arbitrates per cycle, stalls the pipeline when it loses, sequences loader addresses with a counter, and rejects out-of-range accesses.

---
 rtl/dmem_ctrl_pkg.sv | 15 +
 rtl/dmem_rr_arb.sv | 27 ++
 rtl/dmem_ctrl.sv | 137 +++++++++++++
 tb/tb_dmem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and defaults for the data memory access controller
package dmem_ctrl_pkg;

  localparam int unsigned DMEM_DEPTH = 100;
  localparam int unsigned DMEM_AW    = 32;
  localparam int unsigned DMEM_DW    = 32;
  localparam int unsigned DMEM_LENW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-requester round-robin arbiter (CPU vs burst loader)
module dmem_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_ld,
  output logic gnt_cpu,
  output logic gnt_ld
);

  // 1 = loader won the last contended cycle; only contended cycles move it
  logic last_ld_q;

  always_comb begin
    gnt_cpu = req_cpu && (!req_ld || last_ld_q);
    gnt_ld  = req_ld && (!req_cpu || !last_ld_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ld_q <= 1'b1;
    end else if (req_cpu && req_ld) begin
      last_ld_q <= gnt_ld;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-port data memory sharing between MEM stage and burst loader
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = DMEM_AW,
  parameter int unsigned DW    = DMEM_DW,
  parameter int unsigned LENW  = DMEM_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wd,
  output logic [DW-1:0]   cpu_rd,
  output logic            cpu_stall,
  input  logic            ld_start,
  input  logic [AW-1:0]   ld_base,
  input  logic [LENW-1:0] ld_len,
  input  logic            ld_valid,
  input  logic [DW-1:0]   ld_wd,
  output logic            ld_ready,
  output logic            ld_busy,
  output logic            ld_done,
  output logic            ld_err,
  output logic            oor_flag,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wd,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rd
);

  ld_state_e       state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            oor_q, oor_d;

  logic            gnt_cpu, gnt_ld;
  logic [AW:0]     ld_end;
  logic            range_ok;
  logic            cpu_oor;
  logic [AW-1:0]   ld_addr;

  // No grants while reset is held, so the CPU sees a stall and nothing is written
  dmem_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (cpu_req && rst),
    .req_ld  ((state_q == ST_BURST) && ld_valid && rst),
    .gnt_cpu (gnt_cpu),
    .gnt_ld  (gnt_ld)
  );

  assign ld_end   = {1'b0, ld_base} + {{(AW+1-LENW){1'b0}}, ld_len};
  assign range_ok = ld_end <= (AW+1)'(DEPTH);
  assign cpu_oor  = cpu_addr >= AW'(DEPTH);
  assign ld_addr  = base_q + {{(AW-LENW){1'b0}}, cnt_q};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    oor_d   = oor_q | (gnt_cpu & cpu_oor);
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_len == '0) begin
            state_d = ST_DONE;
          end else if (range_ok) begin
            state_d = ST_BURST;
            base_d  = ld_base;
            len_d   = ld_len;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (gnt_ld) begin
          cnt_d = cnt_q + LENW'(1);
          if (cnt_q == len_q - LENW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    cpu_rd   = '0;
    if (gnt_cpu) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      mem_we   = cpu_we && !cpu_oor;
      cpu_rd   = cpu_oor ? '0 : mem_rd;
    end else if (gnt_ld) begin
      mem_addr = ld_addr;
      mem_wd   = ld_wd;
      mem_we   = 1'b1;
    end
  end

  assign cpu_stall = cpu_req && !gnt_cpu;
  assign ld_ready  = gnt_ld;
  assign ld_busy   = (state_q == ST_BURST);
  assign ld_done   = (state_q == ST_DONE);
  assign ld_err    = err_q;
  assign oor_flag  = oor_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a behavioural memory reference
module tb_dmem_ctrl;

  localparam int DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        ld_start;
  logic [31:0] ld_base;
  logic [7:0]  ld_len;
  logic        ld_valid;
  logic [31:0] ld_wd;
  logic        ld_ready, ld_busy, ld_done, ld_err, oor_flag;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural single-port memory; out-of-range reads return junk on purpose
  always @(posedge clk) if (mem_we && mem_addr < DEPTH) mem[mem_addr] <= mem_wd;
  assign mem_rd = (mem_addr < DEPTH) ? mem[mem_addr] : 32'hBAD0_BAD0;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_wd(ld_wd), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_err(ld_err), .oor_flag(oor_flag),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  task automatic quiet();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    ld_start = 0; ld_base = 0; ld_len = 0; ld_valid = 0; ld_wd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); quiet(); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_reset();
    quiet(); rst = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wd = 32'h1234;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ld_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", ld_busy); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%0b exp=0", ld_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall got=%0b exp=1", cpu_stall); end
    n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%0b exp=0", ld_done); end
    n_cmp++; if (ld_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0b exp=0", ld_err); end
    n_cmp++; if (oor_flag !== 1'b0) begin n_bad++; $display("FAIL rst_oor got=%0b exp=0", oor_flag); end
    @(negedge clk); quiet(); rst = 1;
  endtask

  task automatic test_cpu_only();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wd = 32'hDEADBEEF; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cpu_store_stall got=%0b exp=0", cpu_stall); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL cpu_store_we got=%0b exp=1", mem_we); end
    @(negedge clk); cpu_we = 0; cpu_wd = 0; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cpu_load_stall got=%0b exp=0", cpu_stall); end
    n_cmp++; if (cpu_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_load_rd got=%h exp=deadbeef", cpu_rd); end
    @(negedge clk); quiet();
  endtask

  task automatic test_burst();
    int busy_n = 0, ready_n = 0, done_c = -1, idx = 0;
    @(negedge clk); ld_start = 1; ld_base = 10; ld_len = 4; ld_valid = 1; ld_wd = 1; #1;
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL burst_idle_ready got=%0b exp=0", ld_ready); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); ld_start = 0; ld_wd = 32'(idx + 1); #1;
      if (ld_busy) busy_n++;
      if (ld_ready) begin ready_n++; idx++; end
      if (ld_done && done_c < 0) done_c = c;
    end
    quiet();
    n_cmp++; if (busy_n != 4) begin n_bad++; $display("FAIL burst_busy_cycles got=%0d exp=4", busy_n); end
    n_cmp++; if (ready_n != 4) begin n_bad++; $display("FAIL burst_ready_cycles got=%0d exp=4", ready_n); end
    n_cmp++; if (done_c != 5) begin n_bad++; $display("FAIL burst_done_cycle got=%0d exp=5", done_c); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[10+i] !== 32'(i + 1)) begin n_bad++; $display("FAIL burst_word%0d got=%h exp=%h", 10+i, mem[10+i], i+1); end
    end
    n_cmp++; if (mem[14] !== 32'h0) begin n_bad++; $display("FAIL burst_overrun got=%h exp=0", mem[14]); end
  endtask

  task automatic test_contended();
    int busy_n = 0, done_c = -1, idx = 0;
    logic exp_stall;
    do_reset();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 50; cpu_wd = 32'h5A5A0050;
    @(negedge clk); cpu_we = 0; ld_start = 1; ld_base = 0; ld_len = 6; ld_valid = 1; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cont_start_stall got=%0b exp=0", cpu_stall); end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); ld_start = 0; ld_wd = 32'hC0 + 32'(idx); #1;
      exp_stall = (c <= 12) && (c % 2 == 0);
      n_cmp++; if (cpu_stall !== exp_stall) begin n_bad++; $display("FAIL cont_stall_c%0d got=%0b exp=%0b", c, cpu_stall, exp_stall); end
      if (!cpu_stall) begin
        n_cmp++; if (cpu_rd !== 32'h5A5A0050) begin n_bad++; $display("FAIL cont_rd_c%0d got=%h exp=5a5a0050", c, cpu_rd); end
      end
      if (ld_busy) busy_n++;
      if (ld_ready) idx++;
      if (ld_done && done_c < 0) done_c = c;
    end
    quiet();
    n_cmp++; if (busy_n != 12) begin n_bad++; $display("FAIL cont_busy_cycles got=%0d exp=12", busy_n); end
    n_cmp++; if (done_c != 13) begin n_bad++; $display("FAIL cont_done_cycle got=%0d exp=13", done_c); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (mem[i] !== 32'hC0 + 32'(i)) begin n_bad++; $display("FAIL cont_word%0d got=%h exp=%h", i, mem[i], 32'hC0 + i); end
    end
  endtask

  task automatic test_errors();
    int idx = 0;
    bit seen = 0;
    @(negedge clk); ld_start = 1; ld_base = 98; ld_len = 3; ld_valid = 1; ld_wd = 32'hEEEE; #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL err_start_we got=%0b exp=0", mem_we); end
    @(negedge clk); ld_start = 0; #1;
    n_cmp++; if (ld_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse got=%0b exp=1", ld_err); end
    n_cmp++; if (ld_busy !== 1'b0) begin n_bad++; $display("FAIL err_busy got=%0b exp=0", ld_busy); end
    n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL err_done got=%0b exp=0", ld_done); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL err_we got=%0b exp=0", mem_we); end
    @(negedge clk); #1;
    n_cmp++; if (ld_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width got=%0b exp=0", ld_err); end
    @(negedge clk); ld_start = 1; ld_base = 32'hFFFF_FFFE; ld_len = 4;
    @(negedge clk); ld_start = 0; #1;
    n_cmp++; if (ld_err !== 1'b1 || ld_busy !== 1'b0) begin n_bad++; $display("FAIL err_wrap got=err%0b/busy%0b exp=err1/busy0", ld_err, ld_busy); end
    @(negedge clk); ld_start = 1; ld_base = 99; ld_len = 0;
    @(negedge clk); ld_start = 0; #1;
    n_cmp++; if (ld_done !== 1'b1) begin n_bad++; $display("FAIL zero_len_done got=%0b exp=1", ld_done); end
    n_cmp++; if (ld_err !== 1'b0 || ld_busy !== 1'b0) begin n_bad++; $display("FAIL zero_len_side got=err%0b/busy%0b exp=0/0", ld_err, ld_busy); end
    @(negedge clk); #1;
    n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL zero_len_pulse got=%0b exp=0", ld_done); end
    n_cmp++; if (mem[98] !== 32'h0 || mem[99] !== 32'h0) begin n_bad++; $display("FAIL err_no_write got=%h/%h exp=0/0", mem[98], mem[99]); end
    @(negedge clk); ld_start = 1; ld_base = 96; ld_len = 4;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); ld_start = 0; ld_wd = 32'hF0 + 32'(idx); #1;
      if (ld_ready) idx++;
      if (ld_done) seen = 1;
    end
    quiet();
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL edge_burst_timeout got=no_done exp=done"); end
    n_cmp++; if (mem[99] !== 32'hF3) begin n_bad++; $display("FAIL edge_burst_last got=%h exp=f3", mem[99]); end
  endtask

  task automatic test_oor();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 120; cpu_wd = 32'hFFFF; #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL oor_we got=%0b exp=0", mem_we); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL oor_stall got=%0b exp=0", cpu_stall); end
    n_cmp++; if (cpu_rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd got=%h exp=0", cpu_rd); end
    @(negedge clk); cpu_we = 0; #1;
    n_cmp++; if (oor_flag !== 1'b1) begin n_bad++; $display("FAIL oor_flag_set got=%0b exp=1", oor_flag); end
    n_cmp++; if (cpu_rd !== 32'h0) begin n_bad++; $display("FAIL oor_load_rd got=%h exp=0", cpu_rd); end
    @(negedge clk); cpu_we = 1; cpu_addr = 99; cpu_wd = 32'h99; #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL oor_edge99_we got=%0b exp=1", mem_we); end
    @(negedge clk); cpu_addr = 100; #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL oor_edge100_we got=%0b exp=0", mem_we); end
    @(negedge clk); quiet();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (oor_flag !== 1'b1) begin n_bad++; $display("FAIL oor_sticky got=%0b exp=1", oor_flag); end
  endtask

  task automatic test_reset_mid_burst();
    int idx = 0;
    bit seen = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      @(negedge clk); ld_start = (c == 0); ld_base = 20; ld_len = 5; ld_valid = 1; ld_wd = 32'hA0 + 32'(idx); #1;
      if (ld_ready) idx++;
    end
    n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL midrst_progress got=%0d exp=2", idx); end
    @(negedge clk); rst = 0; ld_valid = 0; #1;
    n_cmp++; if (ld_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%0b exp=0", ld_busy); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we got=%0b exp=0", mem_we); end
    n_cmp++; if (oor_flag !== 1'b0) begin n_bad++; $display("FAIL midrst_oor got=%0b exp=0", oor_flag); end
    @(negedge clk); quiet(); rst = 1;
    n_cmp++; if (mem[20] !== 32'hA0 || mem[21] !== 32'hA1 || mem[22] !== 32'h0)
      begin n_bad++; $display("FAIL midrst_partial got=%h/%h/%h exp=a0/a1/0", mem[20], mem[21], mem[22]); end
    idx = 0;
    @(negedge clk); ld_start = 1; ld_base = 30; ld_len = 2; ld_valid = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); ld_start = 0; ld_wd = 32'hB0 + 32'(idx); #1;
      if (ld_ready) idx++;
      if (ld_done) seen = 1;
    end
    quiet();
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_restart_timeout got=no_done exp=done"); end
    n_cmp++; if (mem[30] !== 32'hB0 || mem[31] !== 32'hB1)
      begin n_bad++; $display("FAIL midrst_restart got=%h/%h exp=b0/b1", mem[30], mem[31]); end
  endtask

  task automatic test_random();
    logic [31:0] bd [0:7];
    int base, len, idx, waits;
    bit pend, seen;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    for (int b = 0; b < 8; b++) begin
      len  = $urandom_range(1, 8);
      base = $urandom_range(0, DEPTH - len);
      for (int i = 0; i < 8; i++) bd[i] = $urandom;
      idx = 0; waits = 0; pend = 0; seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        ld_start = (c == 0); ld_base = 32'(base); ld_len = 8'(len);
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_wd = bd[idx < 8 ? idx : 0];
        if (!pend && $urandom_range(0, 1) == 1) begin
          pend = 1; cpu_we = $urandom_range(0, 1); cpu_addr = $urandom_range(0, DEPTH - 1); cpu_wd = $urandom;
        end
        cpu_req = pend;
        #1;
        if (pend && cpu_stall) begin
          waits++;
          n_cmp++; if (waits > 1) begin n_bad++; $display("FAIL rnd_wait b%0d c%0d got=%0d exp<=1", b, c, waits); end
        end else if (pend) begin
          if (!cpu_we) begin
            n_cmp++; if (cpu_rd !== ref_mem[cpu_addr]) begin n_bad++; $display("FAIL rnd_load a%0d got=%h exp=%h", cpu_addr, cpu_rd, ref_mem[cpu_addr]); end
          end else ref_mem[cpu_addr] = cpu_wd;
          pend = 0; waits = 0;
        end
        if (ld_ready) begin
          n_cmp++; if (!ld_valid || idx >= len) begin n_bad++; $display("FAIL rnd_ready b%0d got=idx%0d exp<%0d", b, idx, len); end
          if (idx < len) ref_mem[base + idx] = bd[idx];
          idx++;
        end
        if (ld_done) seen = 1;
      end
      // finish any CPU access still outstanding before the next burst starts
      if (pend) begin
        @(negedge clk); ld_valid = 0; ld_start = 0; cpu_req = 1; #1;
        if (cpu_we) ref_mem[cpu_addr] = cpu_wd;
        else begin
          n_cmp++; if (cpu_rd !== ref_mem[cpu_addr]) begin n_bad++; $display("FAIL rnd_tail_load got=%h exp=%h", cpu_rd, ref_mem[cpu_addr]); end
        end
      end
      @(negedge clk); quiet();
      n_cmp++; if (!seen || idx != len) begin n_bad++; $display("FAIL rnd_burst b%0d got=done%0b/%0d exp=done1/%0d", b, seen, idx, len); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (mem[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rnd_mem%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    test_reset();
    test_cpu_only();
    test_burst();
    test_contended();
    test_errors();
    test_oor();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
